sram1rw_param: RTL and testbench

Parametrised single-port (1RW) synchronous SRAM behavioural model. It is the generalised successor of the fixed-size 1RW macro models used by the synthesis/PAR flow. It adds configurable width, depth, write-mask granularity and read latency. After reset it clears the whole array with a hardware sweep and reports a read-valid strobe. It sits wherever generated cache/scratchpad RAMs are instantiated, as the simulation model behind the SRAM macro wrappers.

---
 rtl/sram1rw_param.sv | 163 ++++++++++++++++
 tb/tb_sram1rw_param.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sram1rw_param.sv
// Parametrised 1RW synchronous SRAM model with a post-reset clear sweep and 1- or 2-cycle read latency.
// Optional per-granule even parity is enabled by defining SRAM1RW_PARITY_EN.
module sram1rw_param #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 256,
  parameter int GRAN   = 8,
  parameter int RD_LAT = 1,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                  CE,
  input  logic                  RST,
  input  logic                  CSB,
  input  logic                  WEB,
  input  logic                  OEB,
  input  logic [AW-1:0]         A,
  input  logic [WIDTH-1:0]      I,
  input  logic [WIDTH/GRAN-1:0] WMB,
  output logic [WIDTH-1:0]      O,
  output logic                  VLD,
  output logic                  BUSY,
  output logic                  PERR
);

  localparam int NG = WIDTH / GRAN;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_badLat
    $error("sram1rw_param: RD_LAT must be 1 or 2");
  end
  if (WIDTH % GRAN != 0) begin : g_badGran
    $error("sram1rw_param: WIDTH must be a multiple of GRAN");
  end

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            clrWe;
  logic            ready, re, we, inRange, xBad, rdErr;
  logic [WIDTH-1:0] rdData;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge CE) begin
    if (RST) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clrWe   = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clrWe = 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign BUSY    = (state_q == S_CLEAR);
  assign ready   = !RST && (state_q == S_READY);
  assign re      = ready && !CSB && !OEB;
  assign we      = ready && !CSB && !WEB;
  assign inRange = ({1'b0, A} < (AW + 1)'(DEPTH));

  // Unknown control or address on a selected cycle poisons the array so misuse is visible in simulation.
`ifndef SYNTHESIS
  assign xBad = (CSB !== 1'b1) && $isunknown({CSB, WEB, OEB, A});
`else
  assign xBad = 1'b0;
`endif

  always_ff @(posedge CE) begin
    if (xBad) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= 'x;
    end else if (!RST && clrWe) begin
      mem_q[cnt_q] <= '0;
    end else if (we && inRange) begin
      for (int g = 0; g < NG; g++)
        if (!WMB[g]) mem_q[A][g*GRAN +: GRAN] <= I[g*GRAN +: GRAN];
    end
  end

  always_comb begin
    rdData = '0;
    if (inRange) rdData = mem_q[A];
  end

`ifdef SRAM1RW_PARITY_EN
  logic [NG-1:0] par_q [DEPTH];

  always_ff @(posedge CE) begin
    if (!RST && clrWe) begin
      par_q[cnt_q] <= '0;
    end else if (we && inRange && !xBad) begin
      for (int g = 0; g < NG; g++)
        if (!WMB[g]) par_q[A][g] <= ^I[g*GRAN +: GRAN];
    end
  end

  always_comb begin
    rdErr = 1'b0;
    if (inRange)
      for (int g = 0; g < NG; g++)
        if ((^mem_q[A][g*GRAN +: GRAN]) != par_q[A][g]) rdErr = 1'b1;
  end
`else
  assign rdErr = 1'b0;
`endif

  // First read stage; read-first on a same-address write falls out of the non-blocking array update.
  logic [WIDTH-1:0] o1_q;
  logic             v1_q, e1_q;

  always_ff @(posedge CE) begin
    if (RST) begin
      o1_q <= '0;
      v1_q <= 1'b0;
      e1_q <= 1'b0;
    end else begin
      v1_q <= re;
      e1_q <= re && rdErr;
      if (xBad)    o1_q <= 'x;
      else if (re) o1_q <= rdData;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] o2_q;
    logic             v2_q, e2_q;

    always_ff @(posedge CE) begin
      if (RST) begin
        o2_q <= '0;
        v2_q <= 1'b0;
        e2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        e2_q <= e1_q;
        if (v1_q) o2_q <= o1_q;
      end
    end

    assign O    = o2_q;
    assign VLD  = v2_q;
    assign PERR = e2_q;
  end else begin : g_lat1
    assign O    = o1_q;
    assign VLD  = v1_q;
    assign PERR = e1_q;
  end

endmodule

// File: tb/tb_sram1rw_param.sv
// Randomised self-checking bench for sram1rw_param: a 256-word RD_LAT=1 instance and a 200-word RD_LAT=2
// instance share stimulus and are compared each cycle against a word-array reference model.
module tb_sram1rw_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0, csb = 1'b1, web = 1'b1, oeb = 1'b1;
  logic [7:0]  a = '0;
  logic [63:0] din = '0;
  logic [7:0]  wmb = '1;
  logic [63:0] o0, o1;
  logic        v0, v1, b0, b1, p0, p1;

  int checksTotal = 0;
  int checksPassed = 0;
  int busyCnt0 = 0, busyCnt1 = 0;

  always #5 clk = ~clk;

  sram1rw_param #(.WIDTH(64), .DEPTH(256), .GRAN(8), .RD_LAT(1)) dut0 (
    .CE(clk), .RST(rst), .CSB(csb), .WEB(web), .OEB(oeb), .A(a), .I(din), .WMB(wmb),
    .O(o0), .VLD(v0), .BUSY(b0), .PERR(p0));

  sram1rw_param #(.WIDTH(64), .DEPTH(200), .GRAN(8), .RD_LAT(2)) dut1 (
    .CE(clk), .RST(rst), .CSB(csb), .WEB(web), .OEB(oeb), .A(a), .I(din), .WMB(wmb),
    .O(o1), .VLD(v1), .BUSY(b1), .PERR(p1));

  // Reference model: plain word arrays, a busy countdown and a read-result delay line per instance.
  logic [63:0] memM [2][256];
  bit          corrupt [2][256];
  int          depthM [2] = '{256, 200};
  int          latM [2] = '{1, 2};
  int          busyLeft [2] = '{0, 0};
  logic [63:0] expO [2];
  logic        expV [2], expP [2];
  logic [63:0] pendD [2];
  logic        pendV [2], pendP [2];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checksTotal++;
    if (obs !== exp) $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    else checksPassed++;
  endtask

  task automatic modelEdge();
    for (int k = 0; k < 2; k++) begin
      logic        rv;
      logic [63:0] rd;
      logic        rp;
      rv = 1'b0; rd = '0; rp = 1'b0;
      if (rst) begin
        busyLeft[k] = depthM[k];
        pendV[k] = 1'b0; pendP[k] = 1'b0;
        expO[k] = '0; expV[k] = 1'b0; expP[k] = 1'b0;
      end else begin
        if (busyLeft[k] > 0) begin
          busyLeft[k]--;
          if (busyLeft[k] == 0)
            for (int j = 0; j < 256; j++) begin
              memM[k][j] = '0;
              corrupt[k][j] = 1'b0;
            end
        end else begin
          if (!csb && !oeb) begin
            rv = 1'b1;
            if (a < depthM[k]) begin
              rd = memM[k][a];
              rp = corrupt[k][a];
            end
          end
          if (!csb && !web && a < depthM[k])
            for (int g = 0; g < 8; g++)
              if (!wmb[g]) memM[k][a][g*8 +: 8] = din[g*8 +: 8];
        end
        if (latM[k] == 1) begin
          expV[k] = rv; expP[k] = rp;
          if (rv) expO[k] = rd;
        end else begin
          expV[k] = pendV[k]; expP[k] = pendP[k];
          if (pendV[k]) expO[k] = pendD[k];
          pendV[k] = rv; pendD[k] = rd; pendP[k] = rp;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic cs, input logic weN, input logic oeN,
                               input logic [7:0] addr, input logic [63:0] d, input logic [7:0] m);
    rst = r; csb = cs; web = weN; oeb = oeN; a = addr; din = d; wmb = m;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    if (b0) busyCnt0++;
    if (b1) busyCnt1++;
    checkOutput("busy0", 64'(b0), 64'(busyLeft[0] > 0));
    checkOutput("busy1", 64'(b1), 64'(busyLeft[1] > 0));
    checkOutput("vld0", 64'(v0), 64'(expV[0]));
    checkOutput("vld1", 64'(v1), 64'(expV[1]));
    checkOutput("dout0", o0, expO[0]);
    checkOutput("dout1", o1, expO[1]);
    checkOutput("perr0", 64'(p0), 64'(expP[0]));
    checkOutput("perr1", 64'(p1), 64'(expP[1]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0, 8'hFF);
  endtask

  task automatic doWrite(input logic [7:0] addr, input logic [63:0] d, input logic [7:0] m);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, addr, d, m);
  endtask

  task automatic doRead(input logic [7:0] addr);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, addr, 64'h0, 8'hFF);
  endtask

  initial begin
    logic [63:0] rnd;

    // Reset, then a read issued during the sweep that must be ignored.
    busyCnt0 = 0; busyCnt1 = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0, 8'hFF);
    for (int i = 0; i < 299; i++) begin
      if (i == 10) doRead(8'h80);
      else idle(1);
    end
    checkOutput("busyLen0", 64'(busyCnt0), 64'd256);
    checkOutput("busyLen1", 64'(busyCnt1), 64'd200);
    doRead(8'h80);
    checkOutput("clrVld0", 64'(v0), 64'd1);
    idle(2);

    // Masked write.
    doWrite(8'd5, 64'h1122334455667788, 8'h00);
    doWrite(8'd5, 64'hFFFFFFFFFFFFFFFF, 8'hF0);
    doRead(8'd5);
    checkOutput("mask0", o0, 64'h11223344FFFFFFFF);
    idle(1);
    checkOutput("mask1", o1, 64'h11223344FFFFFFFF);
    idle(1);

    // Back-to-back reads.
    doWrite(8'd1, 64'h0101010101010101, 8'h00);
    doWrite(8'd2, 64'h0202020202020202, 8'h00);
    doWrite(8'd3, 64'h0303030303030303, 8'h00);
    doRead(8'd1);
    doRead(8'd2);
    doRead(8'd3);
    idle(3);

    // Read-during-write at the same address is read-first.
    doWrite(8'd7, 64'hA, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 64'hB, 8'h00);
    checkOutput("rdwOld0", o0, 64'hA);
    idle(1);
    doRead(8'd7);
    checkOutput("rdwNew0", o0, 64'hB);
    idle(2);

    // Random traffic over low addresses and the region around the smaller instance's end.
    for (int i = 0; i < 800; i++) begin
      rnd = {$urandom, $urandom};
      applyStimulus(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(190, 255)),
                    rnd, 8'($urandom));
    end
    idle(2);

    // Reset mid-sweep restarts the count; then out-of-range access on the 200-word instance.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0, 8'hFF);
    idle(100);
    busyCnt0 = 0; busyCnt1 = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0, 8'hFF);
    idle(259);
    checkOutput("rstBusyLen0", 64'(busyCnt0), 64'd256);
    checkOutput("rstBusyLen1", 64'(busyCnt1), 64'd200);
    doWrite(8'd210, 64'hDEADBEEFCAFEF00D, 8'h00);
    doRead(8'd210);
    checkOutput("oorIn0", o0, 64'hDEADBEEFCAFEF00D);
    idle(1);
    checkOutput("oorVld1", 64'(v1), 64'd1);
    checkOutput("oorData1", o1, 64'h0);
    idle(1);

`ifdef SRAM1RW_PARITY_EN
    doWrite(8'd9, 64'h0, 8'h00);
    dut0.mem_q[9][3] = ~dut0.mem_q[9][3];
    dut1.mem_q[9][3] = ~dut1.mem_q[9][3];
    for (int k = 0; k < 2; k++) begin
      memM[k][9][3] = ~memM[k][9][3];
      corrupt[k][9] = 1'b1;
    end
    doRead(8'd9);
    checkOutput("perrHit0", 64'(p0), 64'd1);
    idle(1);
    checkOutput("perrHit1", 64'(p1), 64'd1);
    doRead(8'd11);
    idle(2);
`endif

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
